trig_coax_tx: RTL

- Transmit end of the inter-board coax trigger link; drives the lines that the trigger board's receiver phase-locks to and decodes.
- Each coax channel carries up to 4 trigger types, time-multiplexed into the 4 phase slots of a free-running 4-tick frame on clk_adc.
- During the periodic sync window it first goes quiet, then sends a fixed burst of phase-reference pulses so the far end can learn the per-channel cable delay.

---
 rtl/trig_coax_tx_pkg.sv | 30 +++
 rtl/trig_coax_tx_if.sv | 23 ++
 rtl/trig_coax_tx_lane.sv | 68 ++++++
 rtl/trig_coax_tx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/trig_coax_tx_pkg.sv
// Shared constants, FSM state type and slot arithmetic for the coax trigger transmitter.
package trig_coax_pkg;

    localparam int NSLOT  = 4;
    localparam int SLOT_W = 2;

    localparam int DEF_QUIET_TICKS = 208;
    localparam int DEF_SYNC_PULSES = 55;
    localparam int DEF_SYNC_SLOT   = 0;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        QUIET  = 2'd1,
        SYNC   = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Frame slot that carries trigger type k (wraps mod 4 through the 2-bit width).
    function automatic logic [SLOT_W-1:0] slot_of_type(input logic [SLOT_W-1:0] base,
                                                       input logic [SLOT_W-1:0] k);
        slot_of_type = base + k;
    endfunction

    // Trigger type carried by a given frame slot.
    function automatic logic [SLOT_W-1:0] type_of_slot(input logic [SLOT_W-1:0] base,
                                                       input logic [SLOT_W-1:0] phase);
        type_of_slot = phase - base;
    endfunction

endpackage

// File: rtl/trig_coax_tx_if.sv
// Control/status bundle of the coax trigger transmitter (everything except clock and reset).
interface trig_coax_tx_if #(
    parameter int NCH = 16
);
    logic                 clk_locked;
    logic                 sync_window;
    logic [NCH*4-1:0]     trig_req;
    logic                 resethist;
    logic [NCH-1:0]       coax_out;
    logic [1:0]           frame_phase;
    logic                 sync_ok;
    logic [15:0]          drop_cnt;

    modport master (
        output clk_locked, sync_window, trig_req, resethist,
        input  coax_out, frame_phase, sync_ok, drop_cnt
    );

    modport slave (
        input  clk_locked, sync_window, trig_req, resethist,
        output coax_out, frame_phase, sync_ok, drop_cnt
    );
endinterface

// File: rtl/trig_coax_tx_lane.sv
// One coax channel: four pending trigger bits, the slot multiplexer and the
// NORMAL-traffic / sync-pulse output select, with a registered line drive.
module trig_coax_tx_lane
    import trig_coax_pkg::*;
#(
    parameter int SYNC_SLOT = DEF_SYNC_SLOT
) (
    input  logic              clk_adc,
    input  logic              nrst,
    input  logic              locked_i,
    input  logic              normal_i,
    input  logic              clear_i,
    input  logic              sync_fire_i,
    input  logic [SLOT_W-1:0] phase_i,
    input  logic [NSLOT-1:0]  req_i,
    output logic              coax_o
);

    localparam logic [SLOT_W-1:0] BASE = SLOT_W'(SYNC_SLOT);

    logic [NSLOT-1:0]  pend_q;
    logic [NSLOT-1:0]  pend_d;
    logic              coax_q;
    logic              coax_d;
    logic [SLOT_W-1:0] ksel_s;

    assign ksel_s = type_of_slot(BASE, phase_i);

    // Pending update: the type owning the current slot is consumed, others accumulate requests.
    always_comb begin
        pend_d = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (clear_i) begin
                pend_d[k] = 1'b0;
            end else if (slot_of_type(BASE, SLOT_W'(k)) == phase_i) begin
                pend_d[k] = 1'b0;
            end else begin
                pend_d[k] = pend_q[k] | req_i[k];
            end
        end
    end

    // Line select: suppressed without lock, slot traffic in NORMAL, sync pulse otherwise.
    always_comb begin
        coax_d = 1'b0;
        if (!locked_i) begin
            coax_d = 1'b0;
        end else if (normal_i) begin
            coax_d = pend_q[ksel_s] | req_i[ksel_s];
        end else begin
            coax_d = sync_fire_i;
        end
    end

    // Pending bits and registered line drive.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            pend_q <= '0;
            coax_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            coax_q <= coax_d;
        end
    end

    assign coax_o = coax_q;

endmodule

// File: rtl/trig_coax_tx.sv
// Coax trigger link transmitter: free-running 4-slot frame, per-channel slot
// multiplexing of trigger types, and the quiet + sync-pulse calibration burst.
module trig_coax_tx
    import trig_coax_pkg::*;
#(
    parameter int NCH         = 16,
    parameter int QUIET_TICKS = DEF_QUIET_TICKS,
    parameter int SYNC_PULSES = DEF_SYNC_PULSES,
    parameter int SYNC_SLOT   = DEF_SYNC_SLOT
) (
    input  logic           clk_adc,
    input  logic           nrst,
    trig_coax_tx_if.slave  bus
);

    localparam int QW = $clog2(QUIET_TICKS + 1);
    localparam int PW = $clog2(SYNC_PULSES + 1);
    localparam logic [QW-1:0]     QLAST = QW'(QUIET_TICKS - 1);
    localparam logic [PW-1:0]     PLAST = PW'(SYNC_PULSES - 1);
    localparam logic [SLOT_W-1:0] BASE  = SLOT_W'(SYNC_SLOT);

    state_e            state_q;
    state_e            state_d;
    logic [SLOT_W-1:0] phase_q;
    logic              sw_q;
    logic [QW-1:0]     qcnt_q;
    logic [QW-1:0]     qcnt_d;
    logic [PW-1:0]     pcnt_q;
    logic [PW-1:0]     pcnt_d;
    logic              sync_ok_q;
    logic              sync_ok_d;
    logic [15:0]       drop_q;
    logic [15:0]       drop_d;

    logic              rise_s;
    logic              normal_s;
    logic              enter_quiet_s;
    logic              clear_s;
    logic              sync_fire_s;
    logic              last_pulse_s;
    logic              drop_s;
    logic [NCH-1:0]    coax_s;

    assign rise_s = bus.sync_window & ~sw_q;

    // FSM state register.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a window rise only counts in NORMAL; a falling window always returns to NORMAL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (rise_s) state_d = QUIET;
                else        state_d = NORMAL;
            end
            QUIET: begin
                if (!bus.sync_window)     state_d = NORMAL;
                else if (qcnt_q == QLAST) state_d = SYNC;
                else                      state_d = QUIET;
            end
            SYNC: begin
                if (!bus.sync_window)               state_d = NORMAL;
                else if (sync_fire_s && last_pulse_s) state_d = DONE;
                else                                state_d = SYNC;
            end
            DONE: begin
                if (!bus.sync_window) state_d = NORMAL;
                else                  state_d = DONE;
            end
            default: state_d = NORMAL;
        endcase
    end

    // FSM outputs: lane controls and counter/flag next values.
    always_comb begin
        normal_s      = (state_q == NORMAL);
        enter_quiet_s = normal_s & rise_s;
        clear_s       = ~normal_s | enter_quiet_s | ~bus.clk_locked;
        sync_fire_s   = (state_q == SYNC) & bus.sync_window & (phase_q == BASE);
        last_pulse_s  = (pcnt_q == PLAST);
        drop_s        = ~normal_s & (|bus.trig_req);

        if (enter_quiet_s)          qcnt_d = '0;
        else if (state_q == QUIET)  qcnt_d = qcnt_q + QW'(1);
        else                        qcnt_d = qcnt_q;

        if (enter_quiet_s)          pcnt_d = '0;
        else if (sync_fire_s)       pcnt_d = pcnt_q + PW'(1);
        else                        pcnt_d = pcnt_q;

        if (enter_quiet_s)                    sync_ok_d = 1'b0;
        else if (sync_fire_s && last_pulse_s) sync_ok_d = 1'b1;
        else                                  sync_ok_d = sync_ok_q;

        if (bus.resethist)                    drop_d = 16'h0000;
        else if (drop_s && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        else                                  drop_d = drop_q;
    end

    // Frame counter, window edge register, burst counters, status and drop counter.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            phase_q   <= 2'd0;
            sw_q      <= 1'b0;
            qcnt_q    <= '0;
            pcnt_q    <= '0;
            sync_ok_q <= 1'b0;
            drop_q    <= 16'h0000;
        end else begin
            phase_q   <= phase_q + 2'd1;
            sw_q      <= bus.sync_window;
            qcnt_q    <= qcnt_d;
            pcnt_q    <= pcnt_d;
            sync_ok_q <= sync_ok_d;
            drop_q    <= drop_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        trig_coax_tx_lane #(
            .SYNC_SLOT (SYNC_SLOT)
        ) u_lane (
            .clk_adc     (clk_adc),
            .nrst        (nrst),
            .locked_i    (bus.clk_locked),
            .normal_i    (normal_s),
            .clear_i     (clear_s),
            .sync_fire_i (sync_fire_s),
            .phase_i     (phase_q),
            .req_i       (bus.trig_req[4*c +: 4]),
            .coax_o      (coax_s[c])
        );
    end

    assign bus.coax_out    = coax_s;
    assign bus.frame_phase = phase_q;
    assign bus.sync_ok     = sync_ok_q;
    assign bus.drop_cnt    = drop_q;

endmodule
